// File: rtl/noc_router_rr_if.sv
// Flit handshake bundle for noc_router_rr: per-port valid/ready/data on the
// input and output sides, plus the dropped-flit error reporting.
interface noc_router_rr_if #(
    parameter int NPORTS = 4,
    parameter int WIDTH  = 16
);
    logic [NPORTS-1:0]       in_valid;
    logic [NPORTS-1:0]       in_ready;
    logic [NPORTS*WIDTH-1:0] in_data;
    logic [NPORTS-1:0]       out_valid;
    logic [NPORTS-1:0]       out_ready;
    logic [NPORTS*WIDTH-1:0] out_data;
    logic                    err_dst;
    logic [15:0]             err_count;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, err_dst, err_count
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, err_dst, err_count
    );
endinterface

// File: rtl/noc_router_rr.sv
// NPORTS-port router: FWFT input FIFOs, per-output round-robin arbitration,
// registered outputs with valid/ready, and drop/count of illegal destinations.
module noc_router_rr #(
    parameter int NPORTS = 4,
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8
) (
    input  logic             clk,
    input  logic             reset,
    noc_router_rr_if.slave   bus
);
    localparam int DSTW = $clog2(NPORTS);
    localparam int PW   = $clog2(DEPTH);

    logic [WIDTH-1:0]               mem_q [NPORTS][DEPTH];
    logic [WIDTH-1:0]               mem_d [NPORTS][DEPTH];
    logic [NPORTS-1:0][PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [NPORTS-1:0][PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [NPORTS-1:0][PW:0]        cnt_q, cnt_d;
    logic [NPORTS-1:0][DSTW-1:0]    rr_q, rr_d;
    logic [NPORTS-1:0]              out_valid_q, out_valid_d;
    logic [NPORTS-1:0][WIDTH-1:0]   out_data_q, out_data_d;
    logic                           err_dst_q, err_dst_d;
    logic [15:0]                    err_count_q, err_count_d;

    logic [NPORTS-1:0][WIDTH-1:0]   in_flit;
    logic [NPORTS-1:0][WIDTH-1:0]   head;
    logic [NPORTS-1:0][DSTW-1:0]    dest;
    logic [NPORTS-1:0]              full, empty, legal, drop, wr, pop, gnt;
    logic [4:0]                     ndrop;
    logic [16:0]                    err_sum;

    assign in_flit = bus.in_data;

    for (genvar i = 0; i < NPORTS; i++) begin : g_in
        assign head[i]  = mem_q[i][rd_ptr_q[i]];
        assign dest[i]  = head[i][DSTW:1];
        assign full[i]  = (cnt_q[i] == (PW+1)'(DEPTH));
        assign empty[i] = (cnt_q[i] == '0);
        // Only a non-power-of-two port count leaves destination codes unused.
        if ((1 << DSTW) == NPORTS) begin : g_pow2
            assign legal[i] = 1'b1;
        end else begin : g_npow2
            assign legal[i] = (int'(dest[i]) < NPORTS);
        end
    end

    assign drop = ~empty & ~legal;

    // Per-output round-robin search; an input can match only one output.
    always_comb begin
        int j;
        j           = 0;
        gnt         = '0;
        pop         = drop;
        rr_d        = rr_q;
        out_valid_d = out_valid_q & ~bus.out_ready;
        out_data_d  = out_data_q;
        for (int k = 0; k < NPORTS; k++) begin
            if (!out_valid_q[k] || bus.out_ready[k]) begin
                for (int off = 0; off < NPORTS; off++) begin
                    j = int'(rr_q[k]) + off;
                    if (j >= NPORTS) j = j - NPORTS;
                    if (!gnt[k] && !empty[j] && legal[j] && int'(dest[j]) == k) begin
                        gnt[k]         = 1'b1;
                        pop[j]         = 1'b1;
                        out_valid_d[k] = 1'b1;
                        out_data_d[k]  = head[j];
                        rr_d[k]        = (j == NPORTS-1) ? '0 : DSTW'(j + 1);
                    end
                end
            end
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr       = bus.in_valid & ~full;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ndrop    = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (wr[i]) mem_d[i][wr_ptr_q[i]] = in_flit[i];
            wr_ptr_d[i] = wr_ptr_q[i] + PW'(wr[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + PW'(pop[i]);
            cnt_d[i]    = cnt_q[i] + (PW+1)'(wr[i]) - (PW+1)'(pop[i]);
            ndrop       = ndrop + 5'(drop[i]);
        end
        err_dst_d   = |drop;
        err_sum     = {1'b0, err_count_q} + 17'(ndrop);
        err_count_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NPORTS; i++) begin
                for (int d = 0; d < DEPTH; d++) mem_q[i][d] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            rr_q        <= '0;
            out_valid_q <= '0;
            out_data_q  <= '0;
            err_dst_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            rr_q        <= rr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            err_dst_q   <= err_dst_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.in_ready  = ~full;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.err_dst   = err_dst_q;
    assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_noc_router_rr.sv
// Directed bench for noc_router_rr: a 4-port and a 3-port instance, scoreboard
// queues filled on input acceptance and drained on output handshakes.
module tb_noc_router_rr;
    logic clk;
    logic reset;

    noc_router_rr_if #(.NPORTS(4), .WIDTH(16)) bus4 ();
    noc_router_rr_if #(.NPORTS(3), .WIDTH(16)) bus3 ();

    noc_router_rr #(.NPORTS(4), .WIDTH(16), .DEPTH(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
    noc_router_rr #(.NPORTS(3), .WIDTH(16), .DEPTH(4)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] exp4 [$];
    logic [15:0] exp3 [$];
    int n_out4 [4];
    int n_pulse3 = 0;

    int sent [4];
    int target [4];
    int dsel [4];
    logic [7:0] tid;
    int rr_order [3] = '{0, 1, 3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flit layout: [15:8] seq, [7:4] source, [3] 0, [2:1] dest, [0] seq lsb
    function automatic logic [15:0] mk(input int src, input int dst, input logic [7:0] seq);
        return {seq, 4'(src), 1'b0, 2'(dst), seq[0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cycle4();
        logic [3:0] acc;
        for (int i = 0; i < 4; i++) begin
            bus4.in_valid[i] = (sent[i] < target[i]);
            bus4.in_data[i*16 +: 16] = mk(i, dsel[i], {tid[7:4], 4'(sent[i])});
        end
        acc = bus4.in_valid & bus4.in_ready;
        tick();
        for (int i = 0; i < 4; i++) sent[i] += int'(acc[i]);
    endtask

    task automatic setup_streams(input logic [7:0] t, input int t0, input int t1, input int t2,
                                 input int t3, input int d0, input int d1, input int d2, input int d3);
        tid = t;
        target = '{t0, t1, t2, t3};
        dsel   = '{d0, d1, d2, d3};
        sent   = '{0, 0, 0, 0};
    endtask

    // Scoreboard monitor for the 4-port router
    logic [15:0] m4_obs;
    int          m4_idx;
    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 4; k++) begin
                if (bus4.out_valid[k] && bus4.out_ready[k]) begin
                    m4_obs = bus4.out_data[k*16 +: 16];
                    m4_idx = -1;
                    for (int n = 0; n < exp4.size(); n++)
                        if (m4_idx < 0 && exp4[n][7:4] == m4_obs[7:4] && int'(exp4[n][2:1]) == k) m4_idx = n;
                    n_out4[k]++;
                    n_vec++;
                    if (m4_idx < 0) begin
                        n_err++;
                        $error("FAIL sb4_unexpected out%0d: observed %0h expected none", k, m4_obs);
                    end else begin
                        assert (m4_obs === exp4[m4_idx]) else begin
                            n_err++;
                            $error("FAIL sb4_data out%0d: observed %0h expected %0h", k, m4_obs, exp4[m4_idx]);
                        end
                        exp4.delete(m4_idx);
                    end
                end
            end
            for (int i = 0; i < 4; i++)
                if (bus4.in_valid[i] && bus4.in_ready[i]) exp4.push_back(bus4.in_data[i*16 +: 16]);
        end
    end

    // Scoreboard monitor for the 3-port router; destination 3 is expected to vanish
    logic [15:0] m3_obs;
    int          m3_idx;
    always @(negedge clk) begin
        if (!reset) begin
            if (bus3.err_dst) n_pulse3++;
            for (int k = 0; k < 3; k++) begin
                if (bus3.out_valid[k] && bus3.out_ready[k]) begin
                    m3_obs = bus3.out_data[k*16 +: 16];
                    m3_idx = -1;
                    for (int n = 0; n < exp3.size(); n++)
                        if (m3_idx < 0 && exp3[n][7:4] == m3_obs[7:4] && int'(exp3[n][2:1]) == k) m3_idx = n;
                    n_vec++;
                    if (m3_idx < 0) begin
                        n_err++;
                        $error("FAIL sb3_unexpected out%0d: observed %0h expected none", k, m3_obs);
                    end else begin
                        assert (m3_obs === exp3[m3_idx]) else begin
                            n_err++;
                            $error("FAIL sb3_data out%0d: observed %0h expected %0h", k, m3_obs, exp3[m3_idx]);
                        end
                        exp3.delete(m3_idx);
                    end
                end
            end
            for (int i = 0; i < 3; i++)
                if (bus3.in_valid[i] && bus3.in_ready[i] && bus3.in_data[i*16+1 +: 2] != 2'd3)
                    exp3.push_back(bus3.in_data[i*16 +: 16]);
        end
    end

    initial begin
        int got, first, last, src, both, base;
        reset = 1'b1;
        bus4.in_valid = '0; bus4.in_data = '0; bus4.out_ready = '0;
        bus3.in_valid = '0; bus3.in_data = '0; bus3.out_ready = '0;
        for (int k = 0; k < 4; k++) n_out4[k] = 0;
        setup_streams(8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        chk("rst_out_valid", 32'(bus4.out_valid), 32'h0);
        chk("rst_out_data", bus4.out_data[31:0], 32'h0);
        chk("rst_err_count", 32'(bus4.err_count), 32'h0);
        chk("rst_err_dst", 32'(bus4.err_dst), 32'h0);
        reset = 1'b0;
        tick();
        chk("rst_in_ready", 32'(bus4.in_ready), 32'hF);

        // single flit, latency 2
        bus4.out_ready = 4'hF;
        bus4.in_valid = 4'b0001;
        bus4.in_data[15:0] = 16'h0005;
        tick();
        bus4.in_valid = '0;
        chk("single_lat1_valid", 32'(bus4.out_valid), 32'h0);
        tick();
        chk("single_lat2_valid", 32'(bus4.out_valid), 32'h4);
        chk("single_lat2_data", 32'(bus4.out_data[47:32]), 32'h0005);
        tick();
        chk("single_after_valid", 32'(bus4.out_valid), 32'h0);

        // round robin: inputs 0,1,3 -> dest 1
        setup_streams(8'h20, 4, 4, 0, 4, 1, 1, 1, 1);
        got = 0; first = -1; last = -1;
        for (int c = 0; c < 40 && got < 12; c++) begin
            drive_cycle4();
            if (bus4.out_valid[1]) begin
                src = int'(bus4.out_data[23:20]);
                chk("rr_src", 32'(src), 32'(rr_order[got % 3]));
                if (first < 0) first = c;
                last = c;
                got++;
            end
        end
        bus4.in_valid = '0;
        chk("rr_count", 32'(got), 32'd12);
        chk("rr_span", 32'(last - first), 32'd11);

        // backpressure on output 2
        bus4.out_ready = 4'b1011;
        setup_streams(8'h30, 6, 0, 0, 0, 2, 0, 0, 0);
        for (int c = 0; c < 10; c++) drive_cycle4();
        chk("bp_accepted", 32'(sent[0]), 32'd5);
        chk("bp_in_ready0", 32'(bus4.in_ready[0]), 32'h0);
        chk("bp_hold_valid", 32'(bus4.out_valid[2]), 32'h1);
        chk("bp_hold_data", 32'(bus4.out_data[47:32]), 32'(mk(0, 2, 8'h30)));
        base = n_out4[2];
        bus4.out_ready = 4'hF;
        for (int c = 0; c < 20; c++) drive_cycle4();
        bus4.in_valid = '0;
        chk("bp_sent", 32'(sent[0]), 32'd6);
        chk("bp_delivered", 32'(n_out4[2] - base), 32'd6);

        // parallel non-conflicting traffic
        setup_streams(8'h40, 8, 8, 0, 0, 3, 0, 0, 0);
        both = 0; first = -1; last = -1;
        for (int c = 0; c < 14; c++) begin
            drive_cycle4();
            if (bus4.out_valid[3] && bus4.out_valid[0]) begin
                if (first < 0) first = c;
                last = c;
                both++;
            end
        end
        bus4.in_valid = '0;
        chk("par_both_cycles", 32'(both), 32'd8);
        chk("par_span", 32'(last - first), 32'd7);
        for (int c = 0; c < 4; c++) tick();
        chk("sb4_drained_a", 32'(exp4.size()), 32'd0);

        // reset mid-traffic with 3 flits buffered
        bus4.out_ready = 4'h0;
        setup_streams(8'h50, 0, 0, 4, 0, 0, 0, 0, 0);
        for (int c = 0; c < 6; c++) drive_cycle4();
        bus4.in_valid = '0;
        chk("mid_sent", 32'(sent[2]), 32'd4);
        chk("mid_valid_before", 32'(bus4.out_valid), 32'h1);
        reset = 1'b1;
        #1;
        chk("mid_valid_async", 32'(bus4.out_valid), 32'h0);
        exp4.delete();
        tick();
        reset = 1'b0;
        tick();
        chk("mid_in_ready", 32'(bus4.in_ready), 32'hF);
        chk("mid_valid_after", 32'(bus4.out_valid), 32'h0);
        bus4.out_ready = 4'hF;
        bus4.in_valid = 4'b1010;
        bus4.in_data[31:16] = mk(1, 0, 8'h51);
        bus4.in_data[63:48] = mk(3, 0, 8'h53);
        tick();
        bus4.in_valid = '0;
        tick();
        chk("mid_rr_first", 32'(bus4.out_data[7:4]), 32'd1);
        tick();
        chk("mid_rr_second", 32'(bus4.out_data[7:4]), 32'd3);
        for (int c = 0; c < 10; c++) tick();
        chk("sb4_drained_b", 32'(exp4.size()), 32'd0);
        chk("err_count4", 32'(bus4.err_count), 32'h0);

        // drop path on the 3-port router
        bus3.out_ready = 3'b111;
        bus3.in_valid = 3'b010;
        bus3.in_data[31:16] = mk(1, 3, 8'h60);
        tick();
        bus3.in_valid = '0;
        chk("drop_err_early", 32'(bus3.err_dst), 32'h0);
        tick();
        chk("drop_err_pulse", 32'(bus3.err_dst), 32'h1);
        chk("drop_count", 32'(bus3.err_count), 32'd1);
        chk("drop_no_out", 32'(bus3.out_valid), 32'h0);
        tick();
        chk("drop_err_clear", 32'(bus3.err_dst), 32'h0);
        chk("drop_count_hold", 32'(bus3.err_count), 32'd1);
        bus3.in_valid = 3'b010;
        bus3.in_data[31:16] = mk(1, 2, 8'h61);
        tick();
        bus3.in_valid = '0;
        chk("drop_legal_lat1", 32'(bus3.out_valid), 32'h0);
        tick();
        chk("drop_legal_valid", 32'(bus3.out_valid), 32'h4);
        chk("drop_legal_data", 32'(bus3.out_data[47:32]), 32'(mk(1, 2, 8'h61)));
        for (int c = 0; c < 6; c++) tick();
        chk("sb3_drained", 32'(exp3.size()), 32'd0);
        chk("drop_pulses", 32'(n_pulse3), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/noc_router_rr.md
Name: noc_router_rr

Overview:
- Parametrised NPORTS-port mesh/ring router, the next generation of the fixed 4-port noc_router.
- Each input port has a first-word-fall-through FIFO.
- Each output port has an independent round-robin arbiter and a registered output stage with valid/ready backpressure.
- Flits whose destination index is illegal are dropped and counted.
- Instantiated once per tile; output port k of one router connects to an input port of a neighbouring router or of the local IP.

Parameters:
- NPORTS, 4, number of input and output ports (2..8).
- WIDTH, 16, flit width in bits; must be ≥ DSTW+1.
- DEPTH, 8, entries per input FIFO; power of two, ≥ 2.
- DSTW, $clog2(NPORTS), width of the destination field (derived localparam, not overridable).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  NPORTS  bit i: flit offered on input i.
- in_data  input  NPORTS*WIDTH  flit for input i at [i*WIDTH +: WIDTH].
- in_ready  output  NPORTS  bit i: input FIFO i not full.
- out_valid  output  NPORTS  bit k: output register k holds a flit.
- out_data  output  NPORTS*WIDTH  flit for output k at [k*WIDTH +: WIDTH].
- out_ready  input  NPORTS  bit k: downstream accepts a flit this cycle.
- err_dst  output  1  one-cycle pulse when at least one flit is dropped.
- err_count  output  16  saturating count of dropped flits.

Behaviour:
- Reset clears, asynchronously:
  - all FIFOs empty, so in_ready = all ones one cycle after reset deasserts;
  - out_valid = 0 and out_data = 0;
  - round-robin pointers rr[k] = 0;
  - err_dst = 0 and err_count = 0.
- Reset asserted mid-operation discards every buffered and in-flight flit; nothing is replayed.
- Flit format:
  - bits [DSTW:1] are the destination output index;
  - bit 0 and bits above DSTW are payload;
  - the flit is forwarded unmodified.
- Input accept: a flit is written when in_valid[i] & in_ready[i]. in_ready[i] = ~full[i] and is combinational from FIFO state only.
- Full FIFO: in_ready[i] = 0 even if a pop occurs in the same cycle (conservative). A flit offered while in_ready = 0 is ignored and the upstream must hold it.
- Head of FIFO i (FWFT) is visible the cycle after its write.
- Output register k is free when ~out_valid[k] | out_ready[k].
- Arbitration (combinational, per output k):
  - requesters = non-empty inputs whose head destination == k;
  - search starts at rr[k] and wraps modulo NPORTS;
  - the first requester wins only if output register k is free.
- Each input can request only one output, so at most one grant per input per cycle. Ungranted heads stay in their FIFO; there is no retain/replay register.
- On a grant to input i for output k, at the clock edge:
  - pop FIFO i;
  - out_data[k] <= head;
  - out_valid[k] <= 1;
  - rr[k] <= (i+1) mod NPORTS.
- rr[k] is unchanged when output k has no grant.
- Output k with out_valid = 1, out_ready = 0 and no grant holds data and valid stable.
- out_ready[k] = 1 with no grant: out_valid[k] <= 0.
- Illegal destination (head dest ≥ NPORTS, possible only when NPORTS is not a power of two):
  - the head is popped the cycle it becomes visible;
  - err_dst pulses for one cycle;
  - err_count increments by the number of inputs dropping that cycle and saturates at 16'hFFFF.
- Latency: flit accepted at edge t is at the FIFO head after t; it is registered at edge t+1 and visible as out_valid from after t+1. Minimum latency is 2 cycles.
- Throughput: one flit per output per cycle.
- Self-loop (dest == own input index) is legal and routed normally.
- FIFO pointers wrap modulo DEPTH. Occupancy is tracked with a DEPTH+1-state counter, so full and empty are unambiguous.

Test Plan:
- Setup for all scenarios: NPORTS=4, WIDTH=16, DEPTH=4.
- Single flit: in_data[0]=16'h0005 (dest 2) on input 0 with out_ready=4'hF -> out_valid[2]=1 and out_data[2]=16'h0005 exactly 2 cycles after acceptance, for one cycle; no other output asserts.
- Round-robin fairness: inputs 0,1,3 each stream 4 flits to dest 1, out_ready[1]=1 -> outputs interleave sources 0,1,3,0,1,3,...; 12 flits in 12 consecutive cycles once started.
- Backpressure: out_ready[2]=0 while input 0 sends 6 flits to dest 2 -> out_valid[2] held with the first flit; FIFO 0 holds 4 flits, so in_ready[0] drops after the 5th accepted flit; releasing out_ready delivers all 6 flits in order, no loss or duplication.
- Parallel non-conflicting traffic: input0->dest3 and input1->dest0 simultaneously, one flit each per cycle -> both outputs sustain 1 flit/cycle.
- Reset mid-traffic: assert reset with 3 flits buffered -> out_valid=0 immediately; after release in_ready=4'hF, rr=0, and no stale flit ever appears.
- Drop path (NPORTS=3 build): flit with dest 3 on input 1 -> never appears on any output; err_dst pulses once; err_count=1; the following legal flit on input 1 is delivered normally.
